fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of decode. It owns the PC and issues single-outstanding requests to instruction memory. It drives the IF/ID pipeline register that feeds decode with instruction, PC and PC+4. It absorbs downstream stalls with a one-entry skid buffer and handles branch/jump redirects, including discarding an in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0000, value driven on if_instruction while if_valid=0

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  decode/hazard unit cannot accept a new IF/ID entry this cycle
redirect  input  1  branch/jump taken: flush and restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0
imem_req  output  1  instruction memory request
imem_addr  output  32  word-aligned fetch address, stable while imem_req=1 until the imem_rvalid cycle
imem_rvalid  input  1  response valid; may assert in the request cycle or any later cycle; ignored when imem_req=0
imem_rdata  input  32  instruction word, valid when imem_rvalid=1
if_valid  output  1  IF/ID entry holds a real instruction
if_instruction  output  32  instruction to decode (opcode [31:26], rs [25:21], rt [20:16], rd [15:11])
if_pc  output  32  address of if_instruction
if_pc_plus4  output  32  if_pc + 4, modulo 2^32

Behaviour:
- Reset (async, any time, including mid-request): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, if_valid=0, if_instruction=NOP_INSTR, if_pc=0, if_pc_plus4=0, skid empty. imem_req is 0 while reset is high and 1 in the first cycle after release.
- Registers: pc (next fetch address), req_addr (address of the outstanding request, drives imem_addr), IF/ID output register, and a skid entry {instr, pc}.
- "Consumed this cycle" means if_valid=1 and stall=0. "Can load" means if_valid=0 or stall=0.
- State FETCH: imem_req=1, imem_addr=req_addr.
  - rvalid and redirect: drop data; pc=req_addr=redirect_pc&~3; if_valid=0; stay in FETCH.
  - rvalid and can load: IF/ID takes {imem_rdata, req_addr, req_addr+4}; if_valid=1; req_addr=pc=req_addr+4; stay in FETCH.
  - rvalid and cannot load: skid takes {imem_rdata, req_addr}; pc=req_addr+4; go to HOLD.
  - no rvalid and redirect: pc=redirect_pc&~3; if_valid=0; go to DRAIN (the request is already in flight).
  - no rvalid, no redirect: if consumed, if_valid=0 (bubble); otherwise hold.
- State HOLD: imem_req=0; IF/ID is held.
  - redirect: discard skid and IF/ID (if_valid=0); req_addr=pc=redirect target; go to FETCH.
  - stall=0: IF/ID takes the skid entry; if_valid=1; req_addr=pc; go to FETCH.
- State DRAIN: imem_req=1; imem_addr=old req_addr (unchanged); if_valid=0.
  - rvalid: discard data; req_addr=pc; go to FETCH.
  - A further redirect in DRAIN only updates pc; the last redirect wins.
- Redirect has priority over stall and rvalid in every state. It clears if_valid at the same edge.
- Throughput and latency:
  - With a zero-latency memory (rvalid in the request cycle), one instruction per cycle.
  - First if_valid appears 1 cycle after reset release.
  - After a redirect, the first valid target instruction appears at edge+1 with zero-latency memory.
- If_instruction drives NOP_INSTR whenever if_valid=0.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.

Decomposition:
- Shared header fetch/fetch_defs.v holds the state encodings (FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2), the default NOP encoding and the PC increment constant 4.
- One sub-module, fetch_skid_buffer: a one-entry {instr, pc} register with load/clear/full. The state machine and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release with zero-latency memory returning addr-as-data -> imem_addr 0,4,8,...; if_pc/if_instruction match one cycle later; if_pc_plus4=if_pc+4; 1 instr/cycle.
- stall=1 for 3 cycles while if_valid=1 (if_pc=8) -> IF/ID holds 8; skid holds 12; imem_req=0 in HOLD; after stall drops, 12 then 16 appear with no loss or duplicate.
- Memory with 3-cycle latency and redirect to 32'h100 in the 2nd wait cycle -> imem_addr holds the old value until rvalid; the old data is discarded; the next request is 0x100; if_valid=0 until 0x100 returns.
- Redirect to 32'h203 in HOLD with stall=1 -> skid and IF/ID flushed; next imem_addr=0x200.
- Redirect and rvalid in the same cycle -> data dropped; if_valid=0 next cycle; fetch resumes at target. Also cover pc=32'hFFFF_FFFC -> next address 0.
- Assert reset while in DRAIN and again in HOLD -> all outputs at their reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Fetch stage shared types: FSM states, IF/ID and skid bundles.
// Also holds the default NOP word and PC increment.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } skid_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between fetch and imem.
// Single outstanding request; addr held until rvalid.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} skid register for downstream stalls.
// Clear wins over load.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  clear_i,
  input  skid_t entry_i,
  output logic  full_o,
  output skid_t entry_o
);

  logic  full_q;
  skid_t entry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      entry_q <= entry_i;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives imem and the IF/ID register.
// Handles stalls via skid buffer and redirects via DRAIN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic          if_valid,
  output logic [31:0]   if_instruction,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_pc_plus4
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_q, req_d;
  if_id_t      ifid_q, ifid_d;

  logic        skid_load;
  logic        skid_clear;
  logic        skid_full;
  skid_t       skid_in;
  skid_t       skid_out;

  logic [31:0] tgt;
  logic [31:0] drain_pc;
  logic        can_load;
  logic        consumed;

  assign tgt      = align_pc(redirect_pc);
  assign can_load = !ifid_q.valid || !stall;
  assign consumed = ifid_q.valid && !stall;
  assign drain_pc = redirect ? tgt : pc_q;

  assign skid_in.instr = imem.imem_rdata;
  assign skid_in.pc    = req_q;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i (skid_in),
    .full_o  (skid_full),
    .entry_o (skid_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, instr: NOP_INSTR,
                   pc: 32'h0, pc_plus4: 32'h0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    ifid_d     = ifid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            pc_d         = tgt;
            req_d        = tgt;
            ifid_d.valid = 1'b0;
          end else if (can_load) begin
            ifid_d = '{valid: 1'b1,
                       instr: imem.imem_rdata,
                       pc: req_q,
                       pc_plus4: req_q + PC_INC};
            pc_d   = req_q + PC_INC;
            req_d  = req_q + PC_INC;
          end else begin
            skid_load = 1'b1;
            pc_d      = req_q + PC_INC;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          // request already in flight; its response must be dropped
          pc_d         = tgt;
          ifid_d.valid = 1'b0;
          state_d      = DRAIN;
        end else if (consumed) begin
          ifid_d.valid = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_clear   = 1'b1;
          ifid_d.valid = 1'b0;
          pc_d         = tgt;
          req_d        = tgt;
          state_d      = FETCH;
        end else if (!stall && skid_full) begin
          skid_clear = 1'b1;
          ifid_d = '{valid: 1'b1,
                     instr: skid_out.instr,
                     pc: skid_out.pc,
                     pc_plus4: skid_out.pc + PC_INC};
          req_d   = pc_q;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        ifid_d.valid = 1'b0;
        pc_d         = drain_pc;
        if (imem.imem_rvalid) begin
          req_d   = drain_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem.imem_req  = !reset && (state_q != HOLD);
  assign imem.imem_addr = req_q;

  assign if_valid       = ifid_q.valid;
  assign if_instruction = ifid_q.valid ? ifid_q.instr : NOP_INSTR;
  assign if_pc          = ifid_q.pc;
  assign if_pc_plus4    = ifid_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an addr-as-data imem model.
// Memory latency is selectable per phase.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int lat = 0;
  int cnt;
  int passed = 0;
  int total = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  // rvalid arrives after lat wait cycles; data is the address
  assign bus.imem_rvalid = bus.imem_req && (cnt == lat);
  assign bus.imem_rdata  = bus.imem_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else if (bus.imem_req) cnt <= bus.imem_rvalid ? 0 : cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [31:0] pc);
    chk({tag, "_v"}, {31'h0, if_valid}, {31'h0, v});
    if (v) begin
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_ins"}, if_instruction, pc);
      chk({tag, "_pc4"}, if_pc_plus4, pc + 32'd4);
    end else begin
      chk({tag, "_nop"}, if_instruction, 32'h0);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_v"}, {31'h0, if_valid}, 32'h0);
    chk({tag, "_ins"}, if_instruction, 32'h0);
    chk({tag, "_pc"}, if_pc, 32'h0);
    chk({tag, "_pc4"}, if_pc_plus4, 32'h0);
  endtask

  task automatic chk_bus(input string tag, input logic req,
                         input logic [31:0] addr);
    chk({tag, "_req"}, {31'h0, bus.imem_req}, {31'h0, req});
    if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_rst("rst0");
    reset = 1'b0;
    #1;
    chk_bus("rel", 1'b1, 32'h0);

    // streaming, zero latency
    tick(); chk_out("s0", 1'b1, 32'h0); chk_bus("s0", 1'b1, 32'h4);
    tick(); chk_out("s1", 1'b1, 32'h4); chk_bus("s1", 1'b1, 32'h8);
    tick(); chk_out("s2", 1'b1, 32'h8); chk_bus("s2", 1'b1, 32'hC);

    // stall 3 cycles
    stall = 1'b1;
    tick(); chk_out("h0", 1'b1, 32'h8); chk_bus("h0", 1'b0, 32'h0);
    tick(); chk_out("h1", 1'b1, 32'h8); chk_bus("h1", 1'b0, 32'h0);
    tick(); chk_out("h2", 1'b1, 32'h8); chk_bus("h2", 1'b0, 32'h0);
    stall = 1'b0;
    tick(); chk_out("u0", 1'b1, 32'hC); chk_bus("u0", 1'b1, 32'h10);
    tick(); chk_out("u1", 1'b1, 32'h10); chk_bus("u1", 1'b1, 32'h14);

    // 3-cycle latency, redirect in 2nd wait cycle
    lat = 3;
    tick(); chk_out("w0", 1'b0, 32'h0); chk_bus("w0", 1'b1, 32'h14);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick(); chk_out("d0", 1'b0, 32'h0); chk_bus("d0", 1'b1, 32'h14);
    redirect = 1'b0;
    tick(); chk_out("d1", 1'b0, 32'h0); chk_bus("d1", 1'b1, 32'h14);
    tick(); chk_out("d2", 1'b0, 32'h0); chk_bus("d2", 1'b1, 32'h100);
    tick(); chk_out("d3", 1'b0, 32'h0);
    tick(); chk_out("d4", 1'b0, 32'h0);
    tick(); chk_out("d5", 1'b0, 32'h0);
    tick(); chk_out("d6", 1'b1, 32'h100); chk_bus("d6", 1'b1, 32'h104);

    // redirect while in HOLD
    lat = 0;
    stall = 1'b1;
    tick(); chk_out("k0", 1'b1, 32'h100); chk_bus("k0", 1'b0, 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    tick(); chk_out("k1", 1'b0, 32'h0); chk_bus("k1", 1'b1, 32'h200);
    redirect = 1'b0;
    stall = 1'b0;
    tick(); chk_out("k2", 1'b1, 32'h200);
    tick(); chk_out("k3", 1'b1, 32'h204);

    // redirect with rvalid, target wraps
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(); chk_out("r0", 1'b0, 32'h0); chk_bus("r0", 1'b1, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick(); chk_out("r1", 1'b1, 32'hFFFF_FFFC); chk_bus("r1", 1'b1, 32'h0);
    chk("r1_wrap", if_pc_plus4, 32'h0);
    tick(); chk_out("r2", 1'b1, 32'h0);

    // reset while in DRAIN
    lat = 3;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick(); chk_out("x0", 1'b0, 32'h0); chk_bus("x0", 1'b1, 32'h4);
    redirect = 1'b0;
    reset = 1'b1;
    #1;
    chk_rst("xr");
    tick();
    lat = 0;
    reset = 1'b0;
    #1;
    chk_bus("xrel", 1'b1, 32'h0);
    tick(); chk_out("x1", 1'b1, 32'h0);

    // reset while in HOLD
    stall = 1'b1;
    tick(); chk_bus("y0", 1'b0, 32'h0); chk_out("y0", 1'b1, 32'h0);
    reset = 1'b1;
    #1;
    chk_rst("yr");
    tick();
    reset = 1'b0;
    stall = 1'b0;
    #1;
    chk_bus("yrel", 1'b1, 32'h0);
    tick(); chk_out("y1", 1'b1, 32'h0);
    tick(); chk_out("y2", 1'b1, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
